// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared types and encodings for the multicycle MIPS control FSM (ITYPE_ALU_EN adds I-type ALU states)
package mips_pkg;

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTE  = 4'd6,
      ALUWB    = 4'd7,
      BRANCH   = 4'd8,
`ifdef ITYPE_ALU_EN
      JUMP     = 4'd9,
      IEXECUTE = 4'd10,
      IWB      = 4'd11
`else
      JUMP     = 4'd9
`endif
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;
   localparam logic [1:0] ALUOP_OR    = 2'b11;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef struct packed {
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic [1:0] pc_src;
      logic       pc_en;
   } ctrl_t;

endpackage

// File: rtl/mips_ctrl_decoder.sv
// rtl/mips_ctrl_decoder.sv - combinational state-to-control-word decode (ITYPE_ALU_EN adds IEXECUTE/IWB)
module mips_ctrl_decoder
   import mips_pkg::*;
#(
   parameter int OPCODE_WIDTH = 6
) (
   input  state_t                  state,
   input  logic [OPCODE_WIDTH-1:0] opcode,
   input  logic                    zero,
   output ctrl_t                   ctrl
);

`ifdef ITYPE_ALU_EN
   localparam logic [OPCODE_WIDTH-1:0] OPC_ANDI = OPCODE_WIDTH'(OP_ANDI);
   localparam logic [OPCODE_WIDTH-1:0] OPC_ORI  = OPCODE_WIDTH'(OP_ORI);
`else
   logic unused_opcode;
   assign unused_opcode = ^opcode;
`endif

   always_comb begin
      ctrl = '0;
      case (state)
         FETCH: begin
            ctrl.ir_write  = 1'b1;
            ctrl.alu_src_b = SRCB_FOUR;
            ctrl.alu_op    = ALUOP_ADD;
            ctrl.pc_src    = PCSRC_ALU;
            ctrl.pc_en     = 1'b1;
         end
         DECODE: ctrl.alu_src_b = SRCB_IMM_SH2;
         MEMADR: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
         end
         MEMREAD: ctrl.iord = 1'b1;
         MEMWB: begin
            ctrl.mem_to_reg = 1'b1;
            ctrl.reg_write  = 1'b1;
         end
         MEMWRITE: begin
            ctrl.iord      = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         EXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_REG;
            ctrl.alu_op    = ALUOP_FUNCT;
         end
         ALUWB: begin
            ctrl.reg_dst   = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         // PC load in BRANCH follows the live zero flag, the one Mealy output
         BRANCH: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_op    = ALUOP_SUB;
            ctrl.pc_src    = PCSRC_ALUOUT;
            ctrl.pc_en     = zero;
         end
         JUMP: begin
            ctrl.pc_src = PCSRC_JUMP;
            ctrl.pc_en  = 1'b1;
         end
`ifdef ITYPE_ALU_EN
         // andi rides the funct class; the funct decoder is overridden outside
         IEXECUTE: begin
            ctrl.alu_src_a = 1'b1;
            ctrl.alu_src_b = SRCB_IMM;
            if (opcode == OPC_ORI)
               ctrl.alu_op = ALUOP_OR;
            else if (opcode == OPC_ANDI)
               ctrl.alu_op = ALUOP_FUNCT;
            else
               ctrl.alu_op = ALUOP_ADD;
         end
         IWB: ctrl.reg_write = 1'b1;
`endif
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/mips_control_fsm.sv
// rtl/mips_control_fsm.sv - multicycle MIPS control FSM top; ITYPE_ALU_EN enables addi/andi/ori
module mips_control_fsm
   import mips_pkg::*;
#(
   parameter int OPCODE_WIDTH = 6
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OPCODE_WIDTH-1:0] Opcode_in,
   input  logic                    Zero_in,
   output logic                    MemWrite,
   output logic                    IorD,
   output logic                    IRWrite,
   output logic                    RegDst,
   output logic                    MemtoReg,
   output logic                    RegWrite,
   output logic                    ALUSrcA,
   output logic [1:0]              ALUSrcB,
   output logic [1:0]              ALUOp,
   output logic [1:0]              PCSrc,
   output logic                    PCEn,
   output logic [3:0]              State_out
);

   localparam logic [OPCODE_WIDTH-1:0] OPC_RTYPE = OPCODE_WIDTH'(OP_RTYPE);
   localparam logic [OPCODE_WIDTH-1:0] OPC_J     = OPCODE_WIDTH'(OP_J);
   localparam logic [OPCODE_WIDTH-1:0] OPC_BEQ   = OPCODE_WIDTH'(OP_BEQ);
   localparam logic [OPCODE_WIDTH-1:0] OPC_LW    = OPCODE_WIDTH'(OP_LW);
   localparam logic [OPCODE_WIDTH-1:0] OPC_SW    = OPCODE_WIDTH'(OP_SW);
`ifdef ITYPE_ALU_EN
   localparam logic [OPCODE_WIDTH-1:0] OPC_ADDI  = OPCODE_WIDTH'(OP_ADDI);
   localparam logic [OPCODE_WIDTH-1:0] OPC_ANDI  = OPCODE_WIDTH'(OP_ANDI);
   localparam logic [OPCODE_WIDTH-1:0] OPC_ORI   = OPCODE_WIDTH'(OP_ORI);
`endif

   state_t state;
   state_t state_next;
   ctrl_t  ctrl;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         state <= FETCH;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = FETCH;
      case (state)
         FETCH: state_next = DECODE;
         DECODE: begin
            case (Opcode_in)
               OPC_LW, OPC_SW: state_next = MEMADR;
               OPC_RTYPE:      state_next = EXECUTE;
               OPC_BEQ:        state_next = BRANCH;
               OPC_J:          state_next = JUMP;
`ifdef ITYPE_ALU_EN
               OPC_ADDI, OPC_ANDI, OPC_ORI: state_next = IEXECUTE;
`endif
               default:        state_next = FETCH;
            endcase
         end
         MEMADR:   state_next = (Opcode_in == OPC_SW) ? MEMWRITE : MEMREAD;
         MEMREAD:  state_next = MEMWB;
         EXECUTE:  state_next = ALUWB;
`ifdef ITYPE_ALU_EN
         IEXECUTE: state_next = IWB;
`endif
         default:  state_next = FETCH;
      endcase
   end

   mips_ctrl_decoder #(
      .OPCODE_WIDTH(OPCODE_WIDTH)
   ) u_decoder (
      .state  (state),
      .opcode (Opcode_in),
      .zero   (Zero_in),
      .ctrl   (ctrl)
   );

   // Write strobes are gated by rst directly so an abort kills them without waiting for a clock
   assign MemWrite  = ctrl.mem_write & rst;
   assign IRWrite   = ctrl.ir_write  & rst;
   assign RegWrite  = ctrl.reg_write & rst;
   assign PCEn      = ctrl.pc_en     & rst;
   assign IorD      = ctrl.iord;
   assign RegDst    = ctrl.reg_dst;
   assign MemtoReg  = ctrl.mem_to_reg;
   assign ALUSrcA   = ctrl.alu_src_a;
   assign ALUSrcB   = ctrl.alu_src_b;
   assign ALUOp     = ctrl.alu_op;
   assign PCSrc     = ctrl.pc_src;
   assign State_out = state;

endmodule

// File: doc/mips_control_fsm.md
MIPS_CONTROL_FSM -- requirements
Module: mips_control_fsm

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 6, meaning the instruction opcode field width.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port Opcode_in  input  OPCODE_WIDTH  the instruction register bits [31:26].
REQ-005 SHALL have port Zero_in  input  1  ALU zero flag, used for beq.
REQ-006 SHALL have the following outputs, each with width and meaning as listed:
- MemWrite, 1: memory write enable.
- IorD, 1: memory address select; 0 = PC, 1 = ALUOut.
- IRWrite, 1: instruction register load.
- RegDst, 1: register destination select; 1 = rd.
- MemtoReg, 1: register write data select; 1 = memory data register.
- RegWrite, 1: register file write enable.
- ALUSrcA, 1: ALU A select; 1 = register A.
- ALUSrcB, 2: ALU B select; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp, 2: ALU operation class; 00 = add, 01 = subtract, 10 = funct field, 11 = or.
- PCSrc, 2: next-PC select; 00 = ALU, 01 = ALUOut, 10 = jump target.
- PCEn, 1: PC load enable.
- State_out, 4: current state encoding.

Function
REQ-007 SHALL implement a Moore FSM with states FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BRANCH, JUMP, IEXECUTE, IWB; all outputs not listed for a state SHALL be 0.
REQ-008 FETCH SHALL drive IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCEn=1, and SHALL go to DECODE.
REQ-009 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00, and SHALL branch on Opcode_in as follows:
- 0x23 or 0x2B: MEMADR.
- 0x00: EXECUTE.
- 0x04: BRANCH.
- 0x02: JUMP.
- 0x08, 0x0C, 0x0D: IEXECUTE (see REQ-020).
- Any other opcode: FETCH.
REQ-010 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, and SHALL go to MEMREAD for 0x23 and to MEMWRITE for 0x2B.
REQ-011 MEMREAD SHALL drive IorD=1 and go to MEMWB; MEMWB SHALL drive RegDst=0, MemtoReg=1, RegWrite=1 and go to FETCH.
REQ-012 MEMWRITE SHALL drive IorD=1, MemWrite=1 and go to FETCH.
REQ-013 EXECUTE SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10 and go to ALUWB; ALUWB SHALL drive RegDst=1, MemtoReg=0, RegWrite=1 and go to FETCH.
REQ-014 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, PCEn=Zero_in (the only Mealy output), and go to FETCH.
REQ-015 JUMP SHALL drive PCSrc=10, PCEn=1 and go to FETCH.
REQ-016 Cycle counts from FETCH to FETCH, inclusive of FETCH, SHALL be: lw 5, sw 4, R-type 4, I-ALU 4, beq 3, j 3, illegal opcode 2.
REQ-017 An illegal opcode SHALL produce no MemWrite, RegWrite or PCEn pulse beyond the one in FETCH.
REQ-018 State_out SHALL equal the internal state register every cycle.

Reset
REQ-019 While rst=0, the FSM SHALL force state FETCH and force MemWrite, IRWrite, RegWrite and PCEn to 0; all other outputs SHALL take their FETCH values. After rst rises, the first rising clk edge SHALL complete a normal FETCH. Assertion of rst in any state, including mid-MEMWRITE, SHALL abort the instruction immediately, with no further writes.

Configuration
REQ-020 With macro ITYPE_ALU_EN defined, opcodes 0x08, 0x0C and 0x0D SHALL go to IEXECUTE. IEXECUTE SHALL drive ALUSrcA=1 and ALUSrcB=10, with ALUOp=00 for 0x08, 11 for 0x0D, and 10 for 0x0C (funct decoder is overridden externally), and go to IWB. IWB SHALL drive RegDst=0, MemtoReg=0, RegWrite=1. Without the macro, the IEXECUTE and IWB states SHALL not exist, and those opcodes SHALL be treated as illegal (REQ-017).

Structure
REQ-021 Package mips_pkg SHALL hold the state enum (4-bit), opcode localparams, and the ALUSrcB, ALUOp and PCSrc encodings.
REQ-022 The next-state logic SHALL reside in mips_control_fsm; the state-to-control-word decode SHALL be sub-module mips_ctrl_decoder (combinational).

Verification
REQ-023 Reset: rst=0 for 3 cycles, then release -> State_out=FETCH during reset; cycle 1 IRWrite=1, PCEn=1; cycle 2 DECODE.
REQ-024 lw: Opcode_in=0x23 -> FETCH, DECODE, MEMADR, MEMREAD (IorD=1), MEMWB (RegWrite=1, MemtoReg=1), then FETCH.
REQ-025 sw: Opcode_in=0x2B -> exactly one MemWrite=1 cycle, in the 4th cycle, with IorD=1.
REQ-026 beq: Opcode_in=0x04 with Zero_in=1 -> PCEn=1, PCSrc=01 in the 3rd cycle; with Zero_in=0 -> PCEn=0.
REQ-027 Illegal and I-type: Opcode_in=0x3F -> DECODE then FETCH, no RegWrite. Opcode_in=0x0D with ITYPE_ALU_EN -> IEXECUTE with ALUOp=11, then IWB with RegWrite=1.
REQ-028 Abort: rst=0 asserted during MEMWRITE -> MemWrite falls to 0 asynchronously and State_out=FETCH.
